dsp_sequencer: RTL and testbench
================================

DSP_SEQUENCER -- requirements
Module: dsp_sequencer

Interface
REQ-001 Parameter INSTR_WIDTH, default 26, SHALL be the width of the instruction word: opcode, then sample address, then parameter address.
REQ-002 Parameter PROG_ADDR_WIDTH, default 10, SHALL be the instruction-memory address width.
REQ-003 Parameter PIPE_DEPTH, default 4, SHALL be the number of core pipeline stages to drain after the last instruction.
REQ-004 clk  in  1  SHALL be the rising-edge clock for all state.
REQ-005 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 frame_start  in  1  SHALL be a one-cycle pulse, one per audio sample frame.
REQ-007 enable  in  1  SHALL gate acceptance of frame_start.
REQ-008 prog_len  in  PROG_ADDR_WIDTH  SHALL give the number of instructions to issue; it is sampled only when a frame is accepted.
REQ-009 overrun_clr  in  1  SHALL clear the overrun flag.
REQ-010 imem_rd_addr  out  PROG_ADDR_WIDTH  SHALL drive the instruction-memory read address.
REQ-011 imem_rd_data  in  INSTR_WIDTH  SHALL carry instruction-memory read data, one cycle after the address.
REQ-012 instruction  out  INSTR_WIDTH  SHALL be the instruction word delivered to the DSP core.
REQ-013 busy  out  1  SHALL indicate that a frame program is in progress.
REQ-014 done  out  1  SHALL pulse high for one cycle at the end of each frame.
REQ-015 overrun  out  1  SHALL be a sticky flag for a frame_start that arrives while busy.
REQ-016 frame_cycles  out  PROG_ADDR_WIDTH+4  SHALL hold the busy-cycle count of the last completed frame.

Function
REQ-017 The state machine SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE SHALL go to RUN on the cycle after frame_start is sampled with enable=1 and prog_len!=0; prog_len SHALL be latched at that edge.
REQ-019 IDLE SHALL go directly to DONE when frame_start is sampled with enable=1 and prog_len==0, so no instruction is issued.
REQ-020 In RUN, imem_rd_addr SHALL equal 0 on the first cycle and increment by 1 each cycle, with no wrap inside a frame.
REQ-021 RUN SHALL go to DRAIN after the cycle in which imem_rd_addr equals latched prog_len-1.
REQ-022 DRAIN SHALL last exactly PIPE_DEPTH+1 cycles and then go to DONE.
REQ-023 DONE SHALL last one cycle, assert done, and return to IDLE.
REQ-024 imem_rd_addr SHALL be 0 whenever the state is not RUN.
REQ-025 instruction SHALL equal imem_rd_data when the previous cycle was RUN, and all-zero (NOP) otherwise.
REQ-026 As a result, exactly prog_len non-NOP-slot words SHALL reach the core per frame, in address order, with fetch-to-issue latency of 1 cycle.
REQ-027 busy SHALL be high in RUN and DRAIN and low in IDLE and DONE.
REQ-028 A frame_start sampled while busy=1 or in DONE SHALL be ignored and SHALL set overrun on the next cycle.
REQ-029 overrun SHALL clear on overrun_clr; if set and clear occur in the same cycle, set SHALL win.
REQ-030 A frame_start sampled with enable=0 in IDLE SHALL be ignored without setting overrun.
REQ-031 Deasserting enable in mid-frame SHALL NOT abort the frame.
REQ-032 A cycle counter SHALL clear on entry to RUN and increment on every busy cycle; its value SHALL load into frame_cycles when entering DONE.
REQ-033 For a prog_len==0 frame, frame_cycles SHALL load 0.
REQ-034 The cycle counter SHALL saturate at all-ones rather than wrap.

Reset
REQ-035 Asserting reset_n low SHALL immediately force state IDLE and drive instruction, imem_rd_addr, busy, done, overrun and frame_cycles to 0, including in mid-frame.
REQ-036 After reset deasserts, no instruction SHALL issue until a new accepted frame_start.

Verification
REQ-037 With PIPE_DEPTH=4 and prog_len=3, frame_start at cycle T SHALL give imem_rd_addr 0,1,2 at T+1..T+3, words 0..2 on instruction at T+2..T+4, busy at T+1..T+8, done at T+9 and frame_cycles=8.
REQ-038 With prog_len=0, frame_start at T SHALL give done at T+1, busy never high, instruction always 0 and frame_cycles=0.
REQ-039 A second frame_start at T+5 of the REQ-037 frame SHALL leave the frame unchanged and set overrun at T+6; overrun_clr and a new frame_start in the same cycle SHALL leave overrun=1.
REQ-040 With enable=0, frame_start SHALL leave busy at 0 and overrun at 0; a following frame_start with enable=1 SHALL run normally.
REQ-041 With prog_len=1023, reset_n pulsed low at T+100 SHALL force all outputs to 0 at once; the next frame SHALL start at address 0.
REQ-042 An 8-bit saturation test SHALL use PROG_ADDR_WIDTH=4 and prog_len=15: frame_cycles SHALL equal 20, which is below the counter maximum.

Source files
------------

// File: rtl/dsp_sequencer.sv
// Frame sequencer for the DSP core: issues prog_len instructions from imem each
// frame, drains the core pipeline, pulses done, and tracks overruns and busy time.
module dsp_sequencer #(
   parameter int INSTR_WIDTH     = 26,
   parameter int PROG_ADDR_WIDTH = 10,
   parameter int PIPE_DEPTH      = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         frame_start,
   input  logic                         enable,
   input  logic [PROG_ADDR_WIDTH-1:0]   prog_len,
   input  logic                         overrun_clr,
   output logic [PROG_ADDR_WIDTH-1:0]   imem_rd_addr,
   input  logic [INSTR_WIDTH-1:0]       imem_rd_data,
   output logic [INSTR_WIDTH-1:0]       instruction,
   output logic                         busy,
   output logic                         done,
   output logic                         overrun,
   output logic [PROG_ADDR_WIDTH+3:0]   frame_cycles
);

   localparam int CW = PROG_ADDR_WIDTH + 4;
   localparam int DW = $clog2(PIPE_DEPTH + 2);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

   state_e                     state_q, state_d;
   logic [PROG_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [PROG_ADDR_WIDTH-1:0] len_q, len_d;
   logic [DW-1:0]              drain_q, drain_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic [CW-1:0]              fcyc_q, fcyc_d;
   logic                       ovr_q, ovr_d;
   logic                       was_run_q;
   logic                       busy_c;

   assign busy_c = (state_q == S_RUN) || (state_q == S_DRAIN);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      drain_d = drain_q;
      cnt_d   = cnt_q;
      fcyc_d  = fcyc_q;
      ovr_d   = ovr_q;

      // Saturating busy-cycle count; cleared again on the next RUN entry.
      if (busy_c && (cnt_q != {CW{1'b1}}))
         cnt_d = cnt_q + CW'(1);

      case (state_q)
         S_IDLE: begin
            if (frame_start && enable) begin
               if (prog_len != '0) begin
                  state_d = S_RUN;
                  len_d   = prog_len;
                  addr_d  = '0;
                  cnt_d   = '0;
               end else begin
                  state_d = S_DONE;
                  fcyc_d  = '0;
               end
            end
         end
         S_RUN: begin
            if (addr_q == len_q - PROG_ADDR_WIDTH'(1)) begin
               state_d = S_DRAIN;
               addr_d  = '0;
               drain_d = '0;
            end else begin
               addr_d = addr_q + PROG_ADDR_WIDTH'(1);
            end
         end
         S_DRAIN: begin
            if (drain_q == DW'(PIPE_DEPTH)) begin
               state_d = S_DONE;
               fcyc_d  = cnt_d;
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A late frame_start outranks a same-cycle clear.
      if (overrun_clr)
         ovr_d = 1'b0;
      if (frame_start && (busy_c || (state_q == S_DONE)))
         ovr_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         drain_q   <= '0;
         cnt_q     <= '0;
         fcyc_q    <= '0;
         ovr_q     <= 1'b0;
         was_run_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         drain_q   <= drain_d;
         cnt_q     <= cnt_d;
         fcyc_q    <= fcyc_d;
         ovr_q     <= ovr_d;
         was_run_q <= (state_q == S_RUN);
      end
   end

   // imem has one cycle of read latency, so the fetch from the previous RUN
   // cycle is what reaches the core; every other slot is a NOP.
   assign imem_rd_addr = (state_q == S_RUN) ? addr_q : '0;
   assign instruction  = was_run_q ? imem_rd_data : '0;
   assign busy         = busy_c;
   assign done         = (state_q == S_DONE);
   assign overrun      = ovr_q;
   assign frame_cycles = fcyc_q;

endmodule

// File: tb/tb_dsp_sequencer.sv
// Bench for dsp_sequencer: cycle-exact frame timing, scoreboarded instruction
// stream, overrun/enable/reset behaviour, and a narrow-address instance.
module tb_dsp_sequencer;
   localparam int IW = 26;
   localparam int AW = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n, frame_start, enable, overrun_clr;
   logic [AW-1:0] prog_len, imem_rd_addr;
   logic [IW-1:0] imem_rd_data, instruction;
   logic          busy, done, overrun;
   logic [AW+3:0] frame_cycles;

   logic          fs2;
   logic [3:0]    len2, addr2;
   logic [IW-1:0] rd2, instr2;
   logic          busy2, done2, ovr2;
   logic [7:0]    fc2;

   int checks = 0;
   int errors = 0;
   int words2 = 0;
   logic [IW-1:0] sb[$];

   dsp_sequencer #(.INSTR_WIDTH(IW), .PROG_ADDR_WIDTH(AW), .PIPE_DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .enable(enable),
      .prog_len(prog_len), .overrun_clr(overrun_clr), .imem_rd_addr(imem_rd_addr),
      .imem_rd_data(imem_rd_data), .instruction(instruction), .busy(busy),
      .done(done), .overrun(overrun), .frame_cycles(frame_cycles));

   dsp_sequencer #(.INSTR_WIDTH(IW), .PROG_ADDR_WIDTH(4), .PIPE_DEPTH(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .frame_start(fs2), .enable(1'b1),
      .prog_len(len2), .overrun_clr(1'b0), .imem_rd_addr(addr2),
      .imem_rd_data(rd2), .instruction(instr2), .busy(busy2),
      .done(done2), .overrun(ovr2), .frame_cycles(fc2));

   function automatic logic [IW-1:0] pat(input int a);
      return IW'(32'h0150000 + a * 3 + 1);
   endfunction

   // Synchronous-read instruction memories
   always @(posedge clk) begin
      imem_rd_data <= pat(int'(imem_rd_addr));
      rd2          <= pat(int'(addr2));
   end

   // Scoreboard: every non-NOP word must be the next expected one
   always @(negedge clk) begin
      if (reset_n && instruction !== '0) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got %h, expected no instruction", instruction);
         end else begin
            logic [IW-1:0] e;
            e = sb.pop_front();
            if (instruction !== e) begin
               errors++;
               $display("FAIL sb_word: got %h, expected %h", instruction, e);
            end
         end
      end
      if (reset_n && instr2 !== '0) begin
         checks++;
         if (instr2 !== pat(words2)) begin
            errors++;
            $display("FAIL dut4_word: got %h, expected %h", instr2, pat(words2));
         end
         words2++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int limit);
      int n;
      n = 0;
      while (done !== 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout: done=%b after %0d cycles, expected 1", done, n);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; frame_start = 1'b0; enable = 1'b1; overrun_clr = 1'b0;
      prog_len = '0; fs2 = 1'b0; len2 = '0;
      #1;
      checks++;
      if ({imem_rd_addr, instruction, busy, done, overrun, frame_cycles} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: addr=%h instr=%h busy=%b done=%b ovr=%b fc=%0d, expected all 0",
                  imem_rd_addr, instruction, busy, done, overrun, frame_cycles);
      end
      repeat (3) step();
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || instruction !== '0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b instr=%h, expected 0/0", busy, instruction);
         end
      end
   endtask

   task automatic test_basic();
      logic [AW-1:0] ea;
      logic [IW-1:0] ei;
      step();
      prog_len = 10'd3; frame_start = 1'b1;
      for (int i = 0; i < 3; i++) sb.push_back(pat(i));
      for (int j = 1; j <= 10; j++) begin
         step();
         frame_start = 1'b0; prog_len = 10'd999;
         @(negedge clk);
         ea = (j <= 3) ? AW'(j - 1) : '0;
         ei = (j >= 2 && j <= 4) ? pat(j - 2) : '0;
         checks++;
         if (imem_rd_addr !== ea) begin
            errors++; $display("FAIL basic_addr T+%0d: got %0d, expected %0d", j, imem_rd_addr, ea);
         end
         checks++;
         if (instruction !== ei) begin
            errors++; $display("FAIL basic_instr T+%0d: got %h, expected %h", j, instruction, ei);
         end
         checks++;
         if (busy !== (j <= 8) || done !== (j == 9)) begin
            errors++; $display("FAIL basic_busy_done T+%0d: got %b/%b, expected %b/%b", j, busy, done, j <= 8, j == 9);
         end
      end
      checks++;
      if (frame_cycles !== 14'd8) begin
         errors++; $display("FAIL basic_frame_cycles: got %0d, expected 8", frame_cycles);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL basic_sb_left: %0d words missing, expected 0", sb.size());
      end
   endtask

   task automatic test_zero_len();
      step();
      prog_len = '0; frame_start = 1'b1;
      for (int j = 1; j <= 4; j++) begin
         step();
         frame_start = 1'b0;
         @(negedge clk);
         checks++;
         if (done !== (j == 1) || busy !== 1'b0 || instruction !== '0) begin
            errors++;
            $display("FAIL zero_len T+%0d: done=%b busy=%b instr=%h, expected %b/0/0", j, done, busy, instruction, j == 1);
         end
      end
      checks++;
      if (frame_cycles !== '0) begin
         errors++; $display("FAIL zero_len_frame_cycles: got %0d, expected 0", frame_cycles);
      end
   endtask

   task automatic test_overrun();
      // Extra frame_start at T+5 must not disturb the running frame
      step();
      prog_len = 10'd3; frame_start = 1'b1;
      for (int i = 0; i < 3; i++) sb.push_back(pat(i));
      for (int j = 1; j <= 10; j++) begin
         step();
         frame_start = (j == 5); prog_len = (j == 5) ? 10'd7 : 10'd3;
         @(negedge clk);
         checks++;
         if (overrun !== (j >= 6) || busy !== (j <= 8) || done !== (j == 9)) begin
            errors++;
            $display("FAIL overrun_frame T+%0d: ovr=%b busy=%b done=%b, expected %b/%b/%b",
                     j, overrun, busy, done, j >= 6, j <= 8, j == 9);
         end
      end
      checks++;
      if (frame_cycles !== 14'd8) begin
         errors++; $display("FAIL overrun_frame_cycles: got %0d, expected 8", frame_cycles);
      end
      // Clear and set in the same cycle: set wins
      step();
      frame_start = 1'b1;
      for (int i = 0; i < 3; i++) sb.push_back(pat(i));
      for (int j = 1; j <= 10; j++) begin
         step();
         frame_start = (j == 2); overrun_clr = (j == 2);
         @(negedge clk);
         if (j == 3) begin
            checks++;
            if (overrun !== 1'b1) begin
               errors++; $display("FAIL overrun_set_wins: got %b, expected 1", overrun);
            end
         end
      end
      step(); overrun_clr = 1'b1;
      step(); overrun_clr = 1'b0;
      @(negedge clk);
      checks++;
      if (overrun !== 1'b0) begin
         errors++; $display("FAIL overrun_clear: got %b, expected 0", overrun);
      end
      // frame_start during DONE is ignored and flagged
      step();
      frame_start = 1'b1;
      for (int i = 0; i < 3; i++) sb.push_back(pat(i));
      for (int j = 1; j <= 11; j++) begin
         step();
         frame_start = (j == 9);
         @(negedge clk);
         if (j >= 10) begin
            checks++;
            if (overrun !== 1'b1 || busy !== 1'b0) begin
               errors++; $display("FAIL overrun_in_done T+%0d: ovr=%b busy=%b, expected 1/0", j, overrun, busy);
            end
         end
      end
      step(); overrun_clr = 1'b1;
      step(); overrun_clr = 1'b0;
   endtask

   task automatic test_enable();
      step();
      enable = 1'b0; prog_len = 10'd3; frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL enable_off: busy=%b ovr=%b, expected 0/0", busy, overrun);
         end
      end
      // enable dropped mid-frame must not abort it
      step();
      enable = 1'b1; prog_len = 10'd5; frame_start = 1'b1;
      for (int i = 0; i < 5; i++) sb.push_back(pat(i));
      for (int j = 1; j <= 12; j++) begin
         step();
         frame_start = 1'b0;
         if (j == 2) enable = 1'b0;
         @(negedge clk);
         checks++;
         if (busy !== (j <= 10) || done !== (j == 11)) begin
            errors++; $display("FAIL enable_mid T+%0d: busy=%b done=%b, expected %b/%b", j, busy, done, j <= 10, j == 11);
         end
      end
      checks++;
      if (frame_cycles !== 14'd10) begin
         errors++; $display("FAIL enable_mid_frame_cycles: got %0d, expected 10", frame_cycles);
      end
      enable = 1'b1;
   endtask

   task automatic test_back_to_back();
      step();
      prog_len = 10'd2; frame_start = 1'b1;
      for (int i = 0; i < 2; i++) sb.push_back(pat(i));
      for (int j = 1; j <= 9; j++) begin
         step();
         frame_start = (j == 9);
         if (j == 9) begin
            prog_len = 10'd4;
            for (int i = 0; i < 4; i++) sb.push_back(pat(i));
         end
         @(negedge clk);
         if (j == 8) begin
            checks++;
            if (done !== 1'b1 || frame_cycles !== 14'd7) begin
               errors++; $display("FAIL b2b_first: done=%b fc=%0d, expected 1/7", done, frame_cycles);
            end
         end
      end
      step();
      frame_start = 1'b0;
      wait_done(20);
      @(negedge clk);
      checks++;
      if (frame_cycles !== 14'd9 || overrun !== 1'b0 || sb.size() != 0) begin
         errors++; $display("FAIL b2b_second: fc=%0d ovr=%b left=%0d, expected 9/0/0", frame_cycles, overrun, sb.size());
      end
   endtask

   task automatic test_reset_midframe();
      step();
      prog_len = 10'd1023; frame_start = 1'b1;
      for (int i = 0; i < 1023; i++) sb.push_back(pat(i));
      for (int j = 1; j <= 99; j++) begin
         step();
         frame_start = (j == 50);
      end
      step();
      reset_n = 1'b0;
      #1;
      checks++;
      if ({imem_rd_addr, instruction, busy, done, overrun, frame_cycles} !== '0) begin
         errors++;
         $display("FAIL reset_mid: addr=%h instr=%h busy=%b done=%b ovr=%b fc=%0d, expected all 0",
                  imem_rd_addr, instruction, busy, done, overrun, frame_cycles);
      end
      sb.delete();
      step(); step();
      reset_n = 1'b1; prog_len = 10'd3;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || instruction !== '0) begin
            errors++; $display("FAIL reset_mid_quiet: busy=%b instr=%h, expected 0/0", busy, instruction);
         end
      end
      step();
      frame_start = 1'b1;
      for (int i = 0; i < 3; i++) sb.push_back(pat(i));
      step();
      frame_start = 1'b0;
      @(negedge clk);
      checks++;
      if (imem_rd_addr !== '0 || busy !== 1'b1) begin
         errors++; $display("FAIL reset_mid_restart: addr=%0d busy=%b, expected 0/1", imem_rd_addr, busy);
      end
      wait_done(20);
      @(negedge clk);
      checks++;
      if (frame_cycles !== 14'd8 || sb.size() != 0) begin
         errors++; $display("FAIL reset_mid_frame: fc=%0d left=%0d, expected 8/0", frame_cycles, sb.size());
      end
   endtask

   task automatic test_narrow();
      int n;
      step();
      words2 = 0; len2 = 4'd15; fs2 = 1'b1;
      step();
      fs2 = 1'b0;
      n = 0;
      while (done2 !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (done2 !== 1'b1) begin
         errors++; $display("FAIL narrow_timeout: done2=%b, expected 1", done2);
      end
      @(negedge clk);
      checks++;
      if (fc2 !== 8'd20 || words2 != 15) begin
         errors++; $display("FAIL narrow_frame: fc=%0d words=%0d, expected 20/15", fc2, words2);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_overrun();
      test_enable();
      test_back_to_back();
      test_reset_midframe();
      test_narrow();
      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
